// File: rtl/int_ctrl.sv
// Single-level interrupt controller: latches rising edges on four request lines,
// presents the highest-priority one to the CPU and tracks its handler until return.
module int_ctrl #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0010,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  irq,
    input  logic        flags_mask,
    input  logic        int_ack,
    input  logic        iret,
    output logic        int_req,
    output logic [15:0] int_vector,
    output logic        mask_int,
    output logic        unmask_int,
    output logic        in_service,
    output logic [3:0]  pending,
    output logic [1:0]  active_id
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE,
        RETURN
    } state_t;

    state_t     state;
    logic [3:0] irq_q;
    logic [3:0] edges;
    logic [3:0] ack_clear;
    logic [1:0] next_id;

    always_comb begin
        edges     = irq & ~irq_q;
        ack_clear = 4'b0000;
        if (state == REQ && int_ack) begin
            ack_clear = 4'b0001 << active_id;
        end
        next_id = 2'd0;
        if (pending[0]) begin
            next_id = 2'd0;
        end else if (pending[1]) begin
            next_id = 2'd1;
        end else if (pending[2]) begin
            next_id = 2'd2;
        end else if (pending[3]) begin
            next_id = 2'd3;
        end
    end

    // Address arithmetic is truncated to 16 bits, so large bases wrap silently.
    assign int_vector = VECTOR_BASE + ({14'b0, active_id} * VECTOR_STRIDE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            irq_q      <= 4'b0000;
            pending    <= 4'b0000;
            active_id  <= 2'd0;
            int_req    <= 1'b0;
            mask_int   <= 1'b0;
            unmask_int <= 1'b0;
            in_service <= 1'b0;
        end else begin
            irq_q <= irq;
            // A fresh edge in the ack cycle overrides the clear of the taken line.
            pending <= (pending & ~ack_clear) | edges;
            case (state)
                IDLE: begin
                    mask_int   <= 1'b0;
                    unmask_int <= 1'b0;
                    if (pending != 4'b0000 && !flags_mask) begin
                        state     <= REQ;
                        active_id <= next_id;
                        int_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state      <= SERVICE;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        mask_int   <= 1'b1;
                    end else if (flags_mask) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    mask_int <= 1'b0;
                    if (iret) begin
                        state      <= RETURN;
                        in_service <= 1'b0;
                        unmask_int <= 1'b1;
                    end
                end
                RETURN: begin
                    state      <= IDLE;
                    unmask_int <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    int_req    <= 1'b0;
                    mask_int   <= 1'b0;
                    unmask_int <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VECTOR_BASE, 16'h0010, base address of the interrupt vector table.
REQ-002 Parameter VECTOR_STRIDE, 16'h0004, address spacing between consecutive vectors.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 irq  input  4  interrupt request lines; rising edge requests service; irq[0] has highest priority.
REQ-006 flags_mask  input  1  current interrupt-mask bit (flags bit 2) from the flags register; 1 = interrupts masked.
REQ-007 int_ack  input  1  CPU accepts the presented interrupt at an instruction boundary.
REQ-008 iret  input  1  one-cycle pulse; CPU executed return-from-interrupt.
REQ-009 int_req  output  1  interrupt request to CPU; held until acknowledged or withdrawn.
REQ-010 int_vector  output  16  handler address for the presented or active interrupt.
REQ-011 mask_int  output  1  one-cycle pulse that sets the flags mask bit.
REQ-012 unmask_int  output  1  one-cycle pulse that clears the flags mask bit.
REQ-013 in_service  output  1  high while a handler is active.
REQ-014 pending  output  4  latched, not-yet-taken requests.
REQ-015 active_id  output  2  index of the presented or serviced request.

Function
REQ-016 Edge detect: irq_q registers irq each cycle; pending[i] sets when irq[i]=1 and irq_q[i]=0.
REQ-017 An edge arriving while pending[i] is already 1 is merged; no count is kept.
REQ-018 States: IDLE, REQ, SERVICE, RETURN; encoding is free.
REQ-019 IDLE -> REQ when pending!=0 and flags_mask=0; active_id latches the lowest set pending index.
REQ-020 In REQ: int_req=1; active_id and int_vector are frozen; a higher-priority edge arriving during REQ does not preempt.
REQ-021 REQ -> SERVICE on int_ack=1; pending[active_id] clears on that edge.
REQ-022 If a new edge on the same line arrives in the ack cycle, set wins and pending[active_id] stays 1.
REQ-023 REQ -> IDLE (withdraw) if flags_mask=1 and int_ack=0; pending is untouched.
REQ-024 int_ack=1 in REQ takes priority over withdrawal in the same cycle.
REQ-025 mask_int=1 for exactly the first cycle in SERVICE; it is 0 at all other times.
REQ-026 In SERVICE: in_service=1, int_req=0, int_vector and active_id hold; new edges still latch into pending.
REQ-027 SERVICE -> RETURN on iret=1.
REQ-028 If iret arrives in the first SERVICE cycle, RETURN still follows and mask_int still pulses.
REQ-029 RETURN lasts one cycle with unmask_int=1, then goes to IDLE.
REQ-030 After RETURN, IDLE evaluates requests normally; a remaining pending request re-enters REQ once flags_mask reads 0.
REQ-031 mask_int and unmask_int are never high in the same cycle.
REQ-032 Nested interrupts are not supported.
REQ-033 iret outside SERVICE is ignored; int_ack outside REQ is ignored.
REQ-034 Software changes to flags_mask during SERVICE do not affect the state.
REQ-035 int_vector = VECTOR_BASE + active_id*VECTOR_STRIDE, computed modulo 2^16 (wraps silently).
REQ-036 int_vector is valid whenever int_req=1 or in_service=1, and is don't-care otherwise.
REQ-037 All outputs are registered or decoded from registered state only; there is no combinational path from irq to any output.

Reset
REQ-038 While rst_n=0 at a clock edge: state=IDLE, pending=0, irq_q=0, active_id=0, and int_req, mask_int, unmask_int, in_service all 0.
REQ-039 Reset mid-operation (REQ, SERVICE or RETURN) abandons the operation with no mask_int or unmask_int pulse.
REQ-040 Because irq_q resets to 0, a line held high through reset release registers one edge.

Verification
REQ-041 flags_mask=0, pulse irq=4'b0100, ack 2 cycles after int_req -> int_req=1, active_id=2, int_vector=16'h0018; after ack, mask_int pulses once and pending=0.
REQ-042 irq[3] and irq[1] edges in the same cycle -> id 1 served first (vector 16'h0014); after its iret and unmask_int, id 3 is presented (vector 16'h001C).
REQ-043 In REQ, flags_mask=1 with no ack -> int_req drops next cycle, pending is unchanged; flags_mask=0 -> the same id is re-presented.
REQ-044 In SERVICE, pulse iret -> RETURN for exactly one cycle with unmask_int=1, then IDLE; a stray iret in IDLE gives no output change.
REQ-045 With VECTOR_BASE=16'hFFFC and STRIDE=4, id 3 -> int_vector=16'h0008 (wrap).
REQ-046 Assert rst_n=0 during SERVICE -> next cycle all outputs are 0 and pending=0; irq[0] held high at release -> pending[0]=1 one cycle later.
